if_fetch_unit: RTL and testbench
================================

# if_fetch_unit

Instruction-fetch stage that produces the `IF_INSTR`/`IF_PC` pair consumed by the IF/ID pipeline register. It owns the fetch PC and runs a request/ready handshake with instruction memory. It buffers one fetched instruction until IF/ID accepts it via `IF_ID_Write`, and takes branch/jump redirects from ID while preserving the MIPS delay slot. When no instruction is available it drives a NOP bubble.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clock`  in  1  clock; all state updates on posedge.
- `reset`  in  1  asynchronous, active-high.
- `IF_ID_Write`  in  1  IF/ID accepts `IF_INSTR`/`IF_PC` at this posedge; low = stall.
- `redirect`  in  1  ID resolved taken branch/jump this cycle.
- `redirect_target`  in  32  target address; valid with `redirect`.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address, word aligned.
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle; meaningful only with `imem_req`.
- `imem_rdata`  in  32  fetched instruction.
- `IF_INSTR`  out  32  instruction offered to IF/ID; 32'd0 (NOP) when buffer empty.
- `IF_PC`  out  32  fetch address + 4 of `IF_INSTR`; 32'd0 when buffer empty.

## Operation
- State: `fetch_pc` (32), `buf_instr`/`buf_pc` (32 each), `buf_valid`, `req_pend` (request issued, not yet answered).
- FSM, two states, encoded by `buf_valid`:
  - EMPTY: `imem_req`=1.
  - FULL: `imem_req` = `IF_ID_Write`, which refills while draining.
- Handshake rules:
  - A transfer completes in any cycle with `imem_req` && `imem_ready`.
  - Once raised, `imem_req` and `imem_addr` stay stable until `imem_ready`. A request is raised only when the buffer is empty after the edge, so this holds by construction.
- Address mux:
  - `req_pend`=1: `imem_addr` = `fetch_pc`, held.
  - New request with `redirect`=1: `imem_addr` = `redirect_target`.
  - Otherwise: `imem_addr` = `fetch_pc`.
- On completion:
  - `buf_instr` ← `imem_rdata`, `buf_pc` ← `imem_addr`+4, `buf_valid` ← 1.
  - `fetch_pc` ← `imem_addr`+4. If `redirect` is high and this was a pending request, `fetch_pc` ← `redirect_target` instead.
- Drain: `buf_valid` && `IF_ID_Write` at posedge → `buf_valid` ← 0, unless refilled the same edge.
- `IF_ID_Write`=0: buffer holds; outputs stable.
- Redirect with delay slot:
  - The instruction in the buffer, or the single pending fetch, is the delay slot. It is never discarded.
  - Only fetches issued after it use the target.
  - If `redirect` arrives with no pending request, the target is used immediately for a request issued this cycle. Otherwise it is latched into `fetch_pc`.
  - Repeated `redirect` before the target is issued: the last target wins.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. Address bits [1:0] are passed unchanged and not checked.

## Timing
- Reset values:
  - `fetch_pc`=`RESET_PC`; `buf_valid`=0; `req_pend`=0.
  - `IF_INSTR`=0; `IF_PC`=0; `imem_req`=0 while reset is asserted.
- Request timing: the first request rises in the first cycle after reset deasserts, with `imem_addr`=`RESET_PC`.
- Latency:
  - `imem_ready` in cycle N → `IF_INSTR` valid in N+1.
  - IF/ID captures at end of N+1 if `IF_ID_Write`.
- Throughput: one instruction per cycle with zero-wait memory (`imem_ready` tied high) and `IF_ID_Write`=1.
- `IF_INSTR`/`IF_PC` are driven directly from registers. `imem_req` and `imem_addr` are combinational from state, `IF_ID_Write` and `redirect`.
- Reset mid-request: the pending fetch is abandoned, and the memory side must tolerate `imem_req` dropping.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR` (32'd0), `DEFAULT_RESET_PC`, `PC_INCR` (4). Reuse existing constants if already present.
- Single module, no sub-modules. The buffer and FSM are too small to split out.

## Test plan
- Zero-wait memory, `IF_ID_Write`=1, reset released → `imem_addr` 0,4,8,… on consecutive cycles. `IF_PC` = 4,8,12,… one cycle later, with no bubbles.
- `imem_ready` delayed 3 cycles on fetch of 0x10 → `imem_addr` held at 0x10 with `imem_req` high for all 3 cycles. `IF_INSTR`=0 during the wait.
- Buffer FULL, `IF_ID_Write` low for 4 cycles → `IF_INSTR`/`IF_PC` constant and `imem_req`=0. Fetch resumes the cycle `IF_ID_Write` returns.
- Buffer holds delay slot at 0x24 (`IF_PC`=0x28); `redirect`=1, target 0x100, `IF_ID_Write`=1 → 0x24 delivered, and same-cycle `imem_addr`=0x100. Next `IF_PC`=0x104.
- Pending fetch at 0x30 with `redirect`=1, target 0x200 → the 0x30 response is kept (`IF_PC`=0x34). The next request is 0x200.
- Assert `reset` while a request is pending → outputs zero immediately. After release, first `imem_addr`=`RESET_PC`.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types.
// Used by the fetch stage and its neighbours.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'd0;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_INCR          = 32'd4;

  typedef enum logic {
    IF_EMPTY = 1'b0,
    IF_FULL  = 1'b1
  } if_state_t;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, talks to imem,
// buffers one instruction for IF/ID and honours the delay slot.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        IF_ID_Write,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_INSTR,
  output logic [31:0] IF_PC
);

  if_state_t   state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic        req_pend, req_pend_n;
  logic        tgt_valid, tgt_valid_n;
  logic [31:0] tgt_pc, tgt_pc_n;
  logic        done;
  logic [31:0] addr_inc;

  // State register; a pending fetch is dropped on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IF_EMPTY;
      fetch_pc  <= RESET_PC;
      buf_instr <= NOP_INSTR;
      buf_pc    <= 32'd0;
      req_pend  <= 1'b0;
      tgt_valid <= 1'b0;
      tgt_pc    <= 32'd0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      buf_instr <= buf_instr_n;
      buf_pc    <= buf_pc_n;
      req_pend  <= req_pend_n;
      tgt_valid <= tgt_valid_n;
      tgt_pc    <= tgt_pc_n;
    end
  end

  // Next-state, request/address mux and redirect bookkeeping.
  // A redirect seen while a fetch is outstanding is parked in
  // tgt_pc, because fetch_pc must keep the pending address stable.
  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    buf_instr_n = buf_instr;
    buf_pc_n    = buf_pc;
    tgt_valid_n = tgt_valid;
    tgt_pc_n    = tgt_pc;
    imem_req    = 1'b0;

    unique case (state)
      IF_EMPTY: imem_req = 1'b1;
      IF_FULL:  imem_req = IF_ID_Write;
      default:  imem_req = 1'b0;
    endcase
    if (reset) imem_req = 1'b0;

    if (req_pend)      imem_addr = fetch_pc;
    else if (redirect) imem_addr = redirect_target;
    else               imem_addr = fetch_pc;

    addr_inc   = imem_addr + PC_INCR;
    done       = imem_req && imem_ready;
    req_pend_n = imem_req && !imem_ready;

    if (done) begin
      if (req_pend && redirect)
        fetch_pc_n = redirect_target;
      else if (req_pend && tgt_valid)
        fetch_pc_n = tgt_pc;
      else
        fetch_pc_n = addr_inc;
      tgt_valid_n = 1'b0;
    end else if (imem_req) begin
      if (!req_pend) begin
        fetch_pc_n = imem_addr;
      end else if (redirect) begin
        tgt_valid_n = 1'b1;
        tgt_pc_n    = redirect_target;
      end
    end else if (redirect) begin
      fetch_pc_n = redirect_target;
    end

    if (done) begin
      state_n     = IF_FULL;
      buf_instr_n = imem_rdata;
      buf_pc_n    = addr_inc;
    end else if (state == IF_FULL && IF_ID_Write) begin
      state_n     = IF_EMPTY;
      buf_instr_n = NOP_INSTR;
      buf_pc_n    = 32'd0;
    end
  end

  assign IF_INSTR = buf_instr;
  assign IF_PC    = buf_pc;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit.
// Memory returns addr | 32'hE000_0000 as the instruction word.
module tb_if_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        IF_ID_Write;
  logic        redirect;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_INSTR;
  logic [31:0] IF_PC;

  int total = 0;
  int bad = 0;

  localparam logic [31:0] TAG = 32'hE000_0000;

  if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clock(clock),
    .reset(reset),
    .IF_ID_Write(IF_ID_Write),
    .redirect(redirect),
    .redirect_target(redirect_target),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .IF_INSTR(IF_INSTR),
    .IF_PC(IF_PC)
  );

  assign imem_rdata = imem_addr | TAG;

  always #5 clock = ~clock;

  task automatic test_reset;
    reset = 1'b1;
    IF_ID_Write = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'd0;
    imem_ready = 1'b0;
    @(posedge clock); #1;
    total++;
    if (imem_req !== 1'b0) begin
      bad++; $display("FAIL rst_req got=%h exp=0", imem_req);
    end
    total++;
    if (IF_INSTR !== 32'd0) begin
      bad++; $display("FAIL rst_instr got=%h exp=0", IF_INSTR);
    end
    total++;
    if (IF_PC !== 32'd0) begin
      bad++; $display("FAIL rst_pc got=%h exp=0", IF_PC);
    end
    reset = 1'b0;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL first_req got=%h/%h exp=1/0", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    logic [31:0] a;
    imem_ready = 1'b1;
    IF_ID_Write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a = 32'(i) * 4;
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        bad++;
        $display("FAIL stream_addr got=%h/%h exp=1/%h",
                 imem_req, imem_addr, a);
      end
      @(posedge clock); #1;
      total++;
      if (IF_PC !== a + 4 || IF_INSTR !== (a | TAG)) begin
        bad++;
        $display("FAIL stream_out got=%h/%h exp=%h/%h",
                 IF_PC, IF_INSTR, a + 4, a | TAG);
      end
    end
  endtask

  task automatic test_wait;
    IF_ID_Write = 1'b1;
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
        bad++;
        $display("FAIL wait_hold got=%h/%h exp=1/10",
                 imem_req, imem_addr);
      end
      @(posedge clock); #1;
      total++;
      if (IF_INSTR !== 32'd0) begin
        bad++; $display("FAIL wait_nop got=%h exp=0", IF_INSTR);
      end
    end
    imem_ready = 1'b1;
    #1;
    total++;
    if (imem_addr !== 32'h10) begin
      bad++; $display("FAIL wait_done_addr got=%h exp=10", imem_addr);
    end
    @(posedge clock); #1;
    total++;
    if (IF_PC !== 32'h14 || IF_INSTR !== 32'hE000_0010) begin
      bad++;
      $display("FAIL wait_out got=%h/%h exp=14/e0000010",
               IF_PC, IF_INSTR);
    end
  endtask

  task automatic test_stall;
    logic [31:0] a;
    IF_ID_Write = 1'b0;
    imem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (imem_req !== 1'b0) begin
        bad++; $display("FAIL stall_req got=%h exp=0", imem_req);
      end
      @(posedge clock); #1;
      total++;
      if (IF_PC !== 32'h14 || IF_INSTR !== 32'hE000_0010) begin
        bad++;
        $display("FAIL stall_hold got=%h/%h exp=14/e0000010",
                 IF_PC, IF_INSTR);
      end
    end
    IF_ID_Write = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a = 32'h14 + 32'(i) * 4;
      #1;
      total++;
      if (imem_req !== 1'b1 || imem_addr !== a) begin
        bad++;
        $display("FAIL resume_addr got=%h/%h exp=1/%h",
                 imem_req, imem_addr, a);
      end
      @(posedge clock); #1;
    end
    total++;
    if (IF_PC !== 32'h28) begin
      bad++; $display("FAIL resume_pc got=%h exp=28", IF_PC);
    end
  endtask

  task automatic test_redirect_buf;
    IF_ID_Write = 1'b1;
    imem_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'h100;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      bad++;
      $display("FAIL rbuf_addr got=%h/%h exp=1/100", imem_req, imem_addr);
    end
    total++;
    if (IF_PC !== 32'h28 || IF_INSTR !== 32'hE000_0024) begin
      bad++;
      $display("FAIL rbuf_slot got=%h/%h exp=28/e0000024",
               IF_PC, IF_INSTR);
    end
    @(posedge clock); #1;
    redirect = 1'b0;
    total++;
    if (IF_PC !== 32'h104 || IF_INSTR !== 32'hE000_0100) begin
      bad++;
      $display("FAIL rbuf_tgt got=%h/%h exp=104/e0000100",
               IF_PC, IF_INSTR);
    end
  endtask

  task automatic test_redirect_pend;
    IF_ID_Write = 1'b1;
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_target = 32'h30;
    #1;
    total++;
    if (imem_addr !== 32'h30) begin
      bad++; $display("FAIL rpend_issue got=%h exp=30", imem_addr);
    end
    @(posedge clock); #1;
    redirect_target = 32'h180;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h30) begin
      bad++;
      $display("FAIL rpend_hold got=%h/%h exp=1/30", imem_req, imem_addr);
    end
    @(posedge clock); #1;
    imem_ready = 1'b1;
    redirect_target = 32'h200;
    #1;
    total++;
    if (imem_addr !== 32'h30) begin
      bad++; $display("FAIL rpend_done_addr got=%h exp=30", imem_addr);
    end
    @(posedge clock); #1;
    redirect = 1'b0;
    total++;
    if (IF_PC !== 32'h34 || IF_INSTR !== 32'hE000_0030) begin
      bad++;
      $display("FAIL rpend_slot got=%h/%h exp=34/e0000030",
               IF_PC, IF_INSTR);
    end
    #1;
    total++;
    if (imem_addr !== 32'h200) begin
      bad++; $display("FAIL rpend_next got=%h exp=200", imem_addr);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_latched_redirect;
    IF_ID_Write = 1'b1;
    imem_ready = 1'b0;
    #1;
    total++;
    if (imem_addr !== 32'h204) begin
      bad++; $display("FAIL latch_issue got=%h exp=204", imem_addr);
    end
    @(posedge clock); #1;
    redirect = 1'b1;
    redirect_target = 32'h400;
    @(posedge clock); #1;
    redirect = 1'b0;
    imem_ready = 1'b1;
    #1;
    total++;
    if (imem_addr !== 32'h204) begin
      bad++; $display("FAIL latch_hold got=%h exp=204", imem_addr);
    end
    @(posedge clock); #1;
    total++;
    if (IF_PC !== 32'h208 || imem_addr !== 32'h400) begin
      bad++;
      $display("FAIL latch_next got=%h/%h exp=208/400", IF_PC, imem_addr);
    end
  endtask

  task automatic test_wrap;
    IF_ID_Write = 1'b1;
    imem_ready = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    #1;
    total++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr);
    end
    @(posedge clock); #1;
    redirect = 1'b0;
    total++;
    if (IF_PC !== 32'd0 || IF_INSTR !== 32'hFFFF_FFFC) begin
      bad++;
      $display("FAIL wrap_pc got=%h/%h exp=0/fffffffc", IF_PC, IF_INSTR);
    end
    #1;
    total++;
    if (imem_addr !== 32'd0) begin
      bad++; $display("FAIL wrap_next got=%h exp=0", imem_addr);
    end
  endtask

  task automatic test_reset_mid;
    IF_ID_Write = 1'b1;
    imem_ready = 1'b1;
    @(posedge clock); #1;
    imem_ready = 1'b0;
    @(posedge clock); #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      bad++;
      $display("FAIL mid_pend got=%h/%h exp=1/4", imem_req, imem_addr);
    end
    @(posedge clock); #1;
    imem_ready = 1'b1;
    @(posedge clock); #1;
    total++;
    if (IF_PC !== 32'h8) begin
      bad++; $display("FAIL mid_full got=%h exp=8", IF_PC);
    end
    imem_ready = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b0 || IF_INSTR !== 32'd0 || IF_PC !== 32'd0) begin
      bad++;
      $display("FAIL mid_rst got=%h/%h/%h exp=0/0/0",
               imem_req, IF_INSTR, IF_PC);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    imem_ready = 1'b1;
    #1;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
      bad++;
      $display("FAIL mid_restart got=%h/%h exp=1/0", imem_req, imem_addr);
    end
    @(posedge clock); #1;
    total++;
    if (IF_PC !== 32'h4 || IF_INSTR !== TAG) begin
      bad++;
      $display("FAIL mid_first got=%h/%h exp=4/e0000000", IF_PC, IF_INSTR);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_wait();
    test_stall();
    test_redirect_buf();
    test_redirect_pend();
    test_latched_redirect();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
